// File: rtl/seg_pair_decoder.sv
// Seven-segment pair receiver: decodes two active-low digits back into a byte
// and checks that the byte stream behaves like an 8-bit up counter.
module seg_pair_decoder #(
    parameter int ERR_W = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             strobe,
    input  logic [6:0]       hex_lo,
    input  logic [6:0]       hex_hi,
    output logic [7:0]       value,
    output logic             valid,
    output logic             bad_pattern,
    output logic             seq_error,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t     state;
    logic       cap_stb;
    logic [6:0] cap_lo;
    logic [6:0] cap_hi;
    logic [7:0] last;

    logic [4:0] dec_lo;
    logic [4:0] dec_hi;
    logic [7:0] dec_val;
    logic [7:0] last_inc;
    logic       legal;
    logic       in_seq;
    logic       err_hit;

    // Returns {legal, nibble}; an unknown glyph decodes to nibble 0.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        logic [4:0] r;
        unique case (seg)
            7'h40:   r = {1'b1, 4'h0};
            7'h79:   r = {1'b1, 4'h1};
            7'h24:   r = {1'b1, 4'h2};
            7'h30:   r = {1'b1, 4'h3};
            7'h19:   r = {1'b1, 4'h4};
            7'h12:   r = {1'b1, 4'h5};
            7'h02:   r = {1'b1, 4'h6};
            7'h78:   r = {1'b1, 4'h7};
            7'h00:   r = {1'b1, 4'h8};
            7'h18:   r = {1'b1, 4'h9};
            7'h08:   r = {1'b1, 4'hA};
            7'h03:   r = {1'b1, 4'hB};
            7'h46:   r = {1'b1, 4'hC};
            7'h21:   r = {1'b1, 4'hD};
            7'h06:   r = {1'b1, 4'hE};
            7'h0E:   r = {1'b1, 4'hF};
            default: r = 5'b0_0000;
        endcase
        return r;
    endfunction

    // Capture the segment buses on a strobe; this is the in-flight sample.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            cap_stb <= 1'b0;
            cap_lo  <= 7'h00;
            cap_hi  <= 7'h00;
        end else begin
            cap_stb <= strobe;
            if (strobe) begin
                cap_lo <= hex_lo;
                cap_hi <= hex_hi;
            end
        end
    end

    // Decode the captured sample and classify it against the reference.
    always_comb begin
        dec_lo   = decode(cap_lo);
        dec_hi   = decode(cap_hi);
        dec_val  = {dec_hi[3:0], dec_lo[3:0]};
        legal    = dec_lo[4] & dec_hi[4];
        last_inc = last + 8'd1;
        in_seq   = (dec_val == last) || (dec_val == last_inc);
        err_hit  = !legal || ((state == LOCKED) && !in_seq);
    end

    // Sequence tracker with registered outputs and saturating error count.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state       <= UNLOCKED;
            last        <= 8'h00;
            value       <= 8'h00;
            valid       <= 1'b0;
            bad_pattern <= 1'b0;
            seq_error   <= 1'b0;
            locked      <= 1'b0;
            err_count   <= '0;
        end else begin
            valid       <= 1'b0;
            bad_pattern <= 1'b0;
            seq_error   <= 1'b0;
            if (cap_stb) begin
                valid <= 1'b1;
                value <= dec_val;
                if (!legal) begin
                    bad_pattern <= 1'b1;
                    state       <= UNLOCKED;
                    locked      <= 1'b0;
                end else begin
                    seq_error <= (state == LOCKED) && !in_seq;
                    state     <= LOCKED;
                    locked    <= 1'b1;
                    last      <= dec_val;
                end
                if (err_hit && (err_count != '1)) begin
                    err_count <= err_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_pair_decoder.sv
// Directed and randomized bench for seg_pair_decoder with a queue scoreboard
// fed by an independent reference model of the decoder and sequence checker.
module tb_seg_pair_decoder;

    localparam int EW = 2;

    logic          clock;
    logic          clear;
    logic          strobe;
    logic [6:0]    hex_lo;
    logic [6:0]    hex_hi;
    logic [7:0]    value;
    logic          valid;
    logic          bad_pattern;
    logic          seq_error;
    logic          locked;
    logic [EW-1:0] err_count;

    seg_pair_decoder #(.ERR_W(EW)) dut (
        .clock       (clock),
        .clear       (clear),
        .strobe      (strobe),
        .hex_lo      (hex_lo),
        .hex_hi      (hex_hi),
        .value       (value),
        .valid       (valid),
        .bad_pattern (bad_pattern),
        .seq_error   (seq_error),
        .locked      (locked),
        .err_count   (err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    localparam logic [6:0] BLANK = 7'h7F;

    typedef struct packed {
        logic [7:0]    v;
        logic          b;
        logic          s;
        logic          l;
        logic [EW-1:0] e;
    } exp_t;

    exp_t sb[$];

    int   checks = 0;
    int   passes = 0;
    logic m_lk;
    logic [7:0] m_last;
    int   m_err;
    logic pipe_stb;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [4:0] mdec(input logic [6:0] seg);
        for (int i = 0; i < 16; i++) begin
            if (GLYPH[i] == seg) return {1'b1, 4'(i)};
        end
        return 5'd0;
    endfunction

    task automatic push(input logic [6:0] hi, input logic [6:0] lo);
        logic [4:0] dh;
        logic [4:0] dl;
        logic [7:0] val;
        logic [7:0] nxt;
        exp_t e;
        dh  = mdec(hi);
        dl  = mdec(lo);
        val = {dh[3:0], dl[3:0]};
        nxt = m_last + 8'd1;
        e   = '0;
        e.v = val;
        if (!(dh[4] && dl[4])) begin
            e.b  = 1'b1;
            m_lk = 1'b0;
        end else begin
            e.s    = m_lk && (val != m_last) && (val != nxt);
            m_lk   = 1'b1;
            m_last = val;
        end
        if ((e.b || e.s) && m_err < (1 << EW) - 1) m_err++;
        e.l = m_lk;
        e.e = EW'(m_err);
        sb.push_back(e);
    endtask

    task automatic tick(input logic stb, input logic [6:0] hi,
                        input logic [6:0] lo);
        logic exp_v;
        exp_t e;
        strobe = stb;
        hex_hi = hi;
        hex_lo = lo;
        if (stb) push(hi, lo);
        exp_v    = pipe_stb;
        pipe_stb = stb;
        @(posedge clock);
        #1;
        chk("valid", 32'(valid), 32'(exp_v));
        if (valid) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("value", 32'(value), 32'(e.v));
                chk("bad_pattern", 32'(bad_pattern), 32'(e.b));
                chk("seq_error", 32'(seq_error), 32'(e.s));
                chk("locked", 32'(locked), 32'(e.l));
                chk("err_count", 32'(err_count), 32'(e.e));
            end
        end else begin
            chk("idle_flags", 32'({bad_pattern, seq_error}), 32'd0);
        end
    endtask

    task automatic tv(input logic [7:0] v);
        tick(1'b1, GLYPH[v[7:4]], GLYPH[v[3:0]]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 7'h7F, 7'h7F);
    endtask

    task automatic do_clear();
        clear  = 1'b1;
        strobe = 1'b0;
        #2;
        m_lk     = 1'b0;
        m_last   = 8'h00;
        m_err    = 0;
        pipe_stb = 1'b0;
        sb.delete();
        chk("rst_value", 32'(value), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_bad", 32'(bad_pattern), 32'd0);
        chk("rst_seq", 32'(seq_error), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        clear = 1'b0;
    endtask

    initial begin
        logic [7:0] cur;
        int r;
        clear    = 1'b1;
        strobe   = 1'b0;
        hex_lo   = 7'h7F;
        hex_hi   = 7'h7F;
        pipe_stb = 1'b0;
        m_lk     = 1'b0;
        m_last   = 8'h00;
        m_err    = 0;
        repeat (2) @(posedge clock);
        #1;
        do_clear();

        tick(1'b1, 7'h40, 7'h79);
        idle(2);

        do_clear();
        tv(8'hFE);
        tick(1'b1, 7'h0E, 7'h0E);
        tick(1'b1, 7'h40, 7'h40);
        idle(2);

        do_clear();
        tv(8'h12);
        tv(8'h12);
        tv(8'h15);
        idle(2);

        do_clear();
        tv(8'h32);
        tick(1'b1, 7'h30, BLANK);
        tv(8'h33);
        tv(8'h34);
        idle(2);

        do_clear();
        for (int i = 0; i < 5; i++) tick(1'b1, BLANK, BLANK);
        tv(8'hA0);
        idle(2);

        do_clear();
        tv(8'h10);
        idle(1);
        tv(8'h11);
        do_clear();
        idle(1);
        chk("mid_clear_locked", 32'(locked), 32'd0);
        chk("mid_clear_value", 32'(value), 32'd0);
        tv(8'h50);
        tv(8'h52);
        idle(2);

        do_clear();
        cur = 8'($urandom_range(0, 255));
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else if (r < 4) begin
                tv(cur);
            end else if (r < 8) begin
                cur = cur + 8'd1;
                tv(cur);
            end else if (r == 8) begin
                cur = 8'($urandom_range(0, 255));
                tv(cur);
            end else begin
                tick(1'b1, GLYPH[cur[7:4]], BLANK);
            end
        end
        idle(2);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
